watch_hhmmss_sync: RTL and testbench

Single-clock-domain successor to the ripple-clocked HH:MM watch top. All counting runs on clk_i through clock enables, with no derived clocks. Adds parametrised crystal frequency, a 12/24-hour display mode, a seconds counter, colon blink, and a two-button time-set state machine with debouncing. Drives four 7-segment digits plus colon and PM indicators.

---
 rtl/watch_hhmmss_sync_pkg.sv | 15 +
 rtl/watch_hhmmss_sync_debounce.sv | 43 ++++
 rtl/watch_hhmmss_sync_seg7.sv | 26 ++
 rtl/watch_hhmmss_sync.sv | 144 ++++++++++++++
 tb/tb_watch_hhmmss_sync.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/watch_hhmmss_sync_pkg.sv
// Shared types and limits for the single-clock HH:MM:SS watch.
package watch_hhmmss_sync_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_HH = 2'b01,
        ST_SET_MM = 2'b10
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [5:0] MAX_SS    = 6'd59;
    localparam logic [5:0] MAX_MM    = 6'd59;
    localparam logic [4:0] MAX_HH    = 5'd23;

endpackage

// File: rtl/watch_hhmmss_sync_debounce.sv
// Button synchroniser, stability filter and rising-edge press event.
module watch_hhmmss_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 655
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            lvl     <= 1'b0;
            cnt     <= '0;
            press_o <= 1'b0;
        end else begin
            s1      <= btn_i;
            s2      <= s1;
            press_o <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                lvl     <= s2;
                cnt     <= '0;
                press_o <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_hhmmss_sync_seg7.sv
// Active-high 7-segment decoder, bit0 = a .. bit6 = g.
module watch_hhmmss_sync_seg7
    import watch_hhmmss_sync_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/watch_hhmmss_sync.sv
// HH:MM:SS watch on one clock with enables, 12/24h display and two-button set.
module watch_hhmmss_sync
    import watch_hhmmss_sync_pkg::*;
#(
    parameter int CLK_HZ          = 32768,
    parameter bit H24             = 1'b1,
    parameter int DEBOUNCE_CYCLES = 655
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       bt_mode_i,
    input  logic       bt_inc_i,
    output logic [6:0] segment_hxxx,
    output logic [6:0] segment_xhxx,
    output logic [6:0] segment_xxmx,
    output logic [6:0] segment_xxxm,
    output logic       colon_o,
    output logic       pm_o,
    output logic       tick1s_o,
    output logic [1:0] set_mode_o
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] presc;
    logic [5:0]    ss;
    logic [5:0]    mm;
    logic [4:0]    hh;
    logic          mode_ev;
    logic          inc_ev;
    logic          tick;
    logic          leave;
    logic          blink;

    watch_hhmmss_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .btn_i  (bt_mode_i),
        .press_o(mode_ev)
    );

    watch_hhmmss_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .btn_i  (bt_inc_i),
        .press_o(inc_ev)
    );

    assign tick  = (state == ST_RUN) && (presc == P_LAST);
    assign leave = (state == ST_SET_MM) && mode_ev;
    assign blink = (presc >= P_HALF);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ST_RUN;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_RUN:    if (mode_ev) state_n = ST_SET_HH;
            ST_SET_HH: if (mode_ev) state_n = ST_SET_MM;
            ST_SET_MM: if (mode_ev) state_n = ST_RUN;
            default:   state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc <= '0;
            ss    <= '0;
            mm    <= '0;
            hh    <= '0;
        end else begin
            presc <= (leave || presc == P_LAST) ? '0 : presc + 1'b1;
            // Leaving set restarts the second so the first tick is a full second away.
            if (leave) begin
                ss <= '0;
            end else if (tick) begin
                if (ss == MAX_SS) begin
                    ss <= '0;
                    if (mm == MAX_MM) begin
                        mm <= '0;
                        hh <= (hh == MAX_HH) ? 5'd0 : hh + 5'd1;
                    end else begin
                        mm <= mm + 6'd1;
                    end
                end else begin
                    ss <= ss + 6'd1;
                end
            end else if (inc_ev && !mode_ev) begin
                if (state == ST_SET_HH)
                    hh <= (hh == MAX_HH) ? 5'd0 : hh + 5'd1;
                else if (state == ST_SET_MM)
                    mm <= (mm == MAX_MM) ? 6'd0 : mm + 6'd1;
            end
        end
    end

    logic [4:0] h12;
    logic [4:0] dh;
    logic [3:0] d_ht;
    logic [3:0] d_hu;
    logic [3:0] d_mt;
    logic [3:0] d_mu;
    logic [6:0] r_ht;
    logic [6:0] r_hu;
    logic [6:0] r_mt;
    logic [6:0] r_mu;
    logic       blank_h;
    logic       blank_m;
    logic       blank_ht;

    assign h12  = hh % 5'd12;
    assign dh   = H24 ? hh : ((h12 == 5'd0) ? 5'd12 : h12);
    assign d_ht = 4'(dh / 5'd10);
    assign d_hu = 4'(dh % 5'd10);
    assign d_mt = 4'(mm / 6'd10);
    assign d_mu = 4'(mm % 6'd10);

    watch_hhmmss_sync_seg7 u_seg_ht (.digit(d_ht), .seg(r_ht));
    watch_hhmmss_sync_seg7 u_seg_hu (.digit(d_hu), .seg(r_hu));
    watch_hhmmss_sync_seg7 u_seg_mt (.digit(d_mt), .seg(r_mt));
    watch_hhmmss_sync_seg7 u_seg_mu (.digit(d_mu), .seg(r_mu));

    assign blank_h  = (state == ST_SET_HH) && blink;
    assign blank_m  = (state == ST_SET_MM) && blink;
    assign blank_ht = blank_h || (!H24 && dh < 5'd10);

    assign segment_hxxx = blank_ht ? SEG_BLANK : r_ht;
    assign segment_xhxx = blank_h  ? SEG_BLANK : r_hu;
    assign segment_xxmx = blank_m  ? SEG_BLANK : r_mt;
    assign segment_xxxm = blank_m  ? SEG_BLANK : r_mu;

    assign colon_o    = (state == ST_RUN) ? ~blink : 1'b1;
    assign pm_o       = (hh >= 5'd12);
    assign tick1s_o   = tick;
    assign set_mode_o = state;

endmodule

// File: tb/tb_watch_hhmmss_sync.sv
// Self-checking bench: 24h and 12h instances driven by the same buttons.
module tb_watch_hhmmss_sync;

    localparam int CLK_HZ = 8;
    localparam int DEB    = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bt_mode = 1'b0;
    logic bt_inc = 1'b0;

    logic [6:0] a_ht, a_hu, a_mt, a_mu;
    logic [6:0] b_ht, b_hu, b_mt, b_mu;
    logic       a_colon, a_pm, a_tick;
    logic       b_colon, b_pm, b_tick;
    logic [1:0] a_mode, b_mode;

    watch_hhmmss_sync #(.CLK_HZ(CLK_HZ), .H24(1'b1), .DEBOUNCE_CYCLES(DEB)) dut24 (
        .clk_i(clk), .rstn_i(rstn), .bt_mode_i(bt_mode), .bt_inc_i(bt_inc),
        .segment_hxxx(a_ht), .segment_xhxx(a_hu),
        .segment_xxmx(a_mt), .segment_xxxm(a_mu),
        .colon_o(a_colon), .pm_o(a_pm), .tick1s_o(a_tick), .set_mode_o(a_mode)
    );

    watch_hhmmss_sync #(.CLK_HZ(CLK_HZ), .H24(1'b0), .DEBOUNCE_CYCLES(DEB)) dut12 (
        .clk_i(clk), .rstn_i(rstn), .bt_mode_i(bt_mode), .bt_inc_i(bt_inc),
        .segment_hxxx(b_ht), .segment_xhxx(b_hu),
        .segment_xxmx(b_mt), .segment_xxxm(b_mu),
        .colon_o(b_colon), .pm_o(b_pm), .tick1s_o(b_tick), .set_mode_o(b_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [27:0] d24;
        logic [27:0] d12;
        logic        pm;
        logic [1:0]  mode;
    } exp_t;

    typedef struct {
        int         hh;
        logic [6:0] t24;
        logic [6:0] u24;
        logic [6:0] t12;
        logic [6:0] u12;
        logic       pm;
    } hvec_t;

    exp_t  sbq[$];
    hvec_t tbl[7];

    int checks = 0;
    int failures = 0;
    int m_hh = 0;
    int m_mm = 0;
    int m_st = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int hh, input int mm, input bit h24);
        int dh;
        logic [6:0] t;
        dh = h24 ? hh : ((hh % 12 == 0) ? 12 : hh % 12);
        t = (!h24 && dh < 10) ? 7'h00 : seg(dh / 10);
        return {t, seg(dh % 10), seg(mm / 10), seg(mm % 10)};
    endfunction

    task automatic push_exp(input string name, input logic [27:0] d24,
                            input logic [27:0] d12, input logic pm,
                            input logic [1:0] mode);
        exp_t e;
        e.name = name;
        e.d24 = d24;
        e.d12 = d12;
        e.pm = pm;
        e.mode = mode;
        sbq.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sbq.pop_front();
        chk({e.name, "_d24"}, {a_ht, a_hu, a_mt, a_mu}, e.d24);
        chk({e.name, "_d12"}, {b_ht, b_hu, b_mt, b_mu}, e.d12);
        chk({e.name, "_pm"}, {b_pm, a_pm}, {e.pm, e.pm});
        chk({e.name, "_mode"}, {b_mode, a_mode}, {e.mode, e.mode});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        bt_mode = m;
        bt_inc = i;
        repeat (6) cyc();
        bt_mode = 1'b0;
        bt_inc = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic do_mode();
        press(1'b1, 1'b0);
        m_st = (m_st + 1) % 3;
    endtask

    task automatic do_inc(input int n);
        for (int k = 0; k < n; k++) begin
            press(1'b0, 1'b1);
            if (m_st == 1) m_hh = (m_hh + 1) % 24;
            if (m_st == 2) m_mm = (m_mm + 1) % 60;
        end
    endtask

    task automatic set_hh(input int target);
        do_mode();
        do_inc((target - m_hh + 24) % 24);
        do_mode();
        do_mode();
    endtask

    task automatic wait_tick(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 4 * CLK_HZ; k++) begin
            if (a_tick) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_shown(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2 * CLK_HZ; k++) begin
            if (a_hu != 7'h00 && a_mu != 7'h00) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) chk({name, "_shown_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int blanks;
        int shown;
        bit got;

        tbl[0] = '{0,  7'h3F, 7'h3F, 7'h06, 7'h5B, 1'b0};
        tbl[1] = '{9,  7'h3F, 7'h6F, 7'h00, 7'h6F, 1'b0};
        tbl[2] = '{11, 7'h06, 7'h06, 7'h06, 7'h06, 1'b0};
        tbl[3] = '{12, 7'h06, 7'h5B, 7'h06, 7'h5B, 1'b1};
        tbl[4] = '{13, 7'h06, 7'h4F, 7'h00, 7'h06, 1'b1};
        tbl[5] = '{22, 7'h5B, 7'h5B, 7'h06, 7'h3F, 1'b1};
        tbl[6] = '{23, 7'h5B, 7'h4F, 7'h06, 7'h06, 1'b1};

        repeat (2) cyc();
        push_exp("reset", 28'h7EFDFBF, {7'h06, 7'h5B, 7'h3F, 7'h3F}, 1'b0, 2'b00);
        sb_check();
        chk("reset_colon", {b_colon, a_colon}, 2'b11);
        chk("reset_tick", {b_tick, a_tick}, 2'b00);

        rstn = 1'b1;
        chk("colon_c0", a_colon, 1'b1);
        chk("tick_c0", a_tick, 1'b0);
        for (int k = 1; k <= 2 * CLK_HZ; k++) begin
            cyc();
            chk($sformatf("colon_c%0d", k), a_colon, ((k % CLK_HZ) < CLK_HZ / 2));
            chk($sformatf("tick_c%0d", k), a_tick, ((k % CLK_HZ) == CLK_HZ - 1));
        end

        do_mode();
        do_inc(23);
        do_mode();
        do_inc(59);
        do_mode();
        push_exp("set2359", disp(23, 59, 1), disp(23, 59, 0), 1'b1, 2'b00);
        sb_check();
        for (int t = 0; t < 59; t++) begin
            wait_tick("tick59");
            cyc();
        end
        push_exp("before_roll", disp(23, 59, 1), disp(23, 59, 0), 1'b1, 2'b00);
        sb_check();
        wait_tick("tick60");
        chk("pm_at_roll_tick", a_pm, 1'b1);
        cyc();
        m_hh = 0;
        m_mm = 0;
        push_exp("rollover", disp(0, 0, 1), disp(0, 0, 0), 1'b0, 2'b00);
        sb_check();

        do_mode();
        chk("mode_set_hh", a_mode, 2'b01);
        blanks = 0;
        shown = 0;
        for (int k = 0; k < CLK_HZ; k++) begin
            if (a_ht == 7'h00 && a_hu == 7'h00) blanks++;
            if (a_mt == 7'h3F && a_mu == 7'h3F) shown++;
            cyc();
        end
        chk("hh_blink_cycles", blanks, CLK_HZ / 2);
        chk("mm_shown_cycles", shown, CLK_HZ);
        do_inc(13);
        wait_shown("hh13");
        push_exp("hh13", disp(13, 0, 1), disp(13, 0, 0), 1'b1, 2'b01);
        sb_check();
        do_mode();
        chk("mode_set_mm", a_mode, 2'b10);
        do_inc(61);
        wait_shown("mm01");
        push_exp("mm01", disp(13, 1, 1), disp(13, 1, 0), 1'b1, 2'b10);
        sb_check();

        bt_mode = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (a_mode == 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        chk("leave_seen", got, 1'b1);
        n = 0;
        for (int k = 0; k < 4 * CLK_HZ; k++) begin
            cyc();
            n++;
            if (a_tick) break;
        end
        chk("edges_leave_to_tick", n, CLK_HZ - 1);
        n = 0;
        for (int k = 0; k < 4 * CLK_HZ; k++) begin
            cyc();
            n++;
            if (a_tick) break;
        end
        chk("tick_interval", n, CLK_HZ);
        chk("held_mode_no_repeat", a_mode, 2'b00);
        bt_mode = 1'b0;
        repeat (6) cyc();
        m_st = 0;

        do_inc(1);
        push_exp("inc_in_run", disp(13, 1, 1), disp(13, 1, 0), 1'b1, 2'b00);
        sb_check();

        for (int i = 0; i < 7; i++) begin
            set_hh(tbl[i].hh);
            push_exp($sformatf("tbl_hh%0d", tbl[i].hh),
                     {tbl[i].t24, tbl[i].u24, seg(m_mm / 10), seg(m_mm % 10)},
                     {tbl[i].t12, tbl[i].u12, seg(m_mm / 10), seg(m_mm % 10)},
                     tbl[i].pm, 2'b00);
            sb_check();
        end

        do_mode();
        do_mode();
        bt_inc = 1'b1;
        cyc();
        bt_inc = 1'b0;
        repeat (8) cyc();
        wait_shown("glitch");
        push_exp("glitch", disp(m_hh, m_mm, 1), disp(m_hh, m_mm, 0), 1'b1, 2'b10);
        sb_check();
        do_mode();
        do_mode();
        press(1'b1, 1'b1);
        m_st = 2;
        wait_shown("mode_wins");
        push_exp("mode_wins", disp(23, 1, 1), disp(23, 1, 0), 1'b1, 2'b10);
        sb_check();

        do_inc(36);
        wait_shown("mm37");
        push_exp("mm37", disp(23, 37, 1), disp(23, 37, 0), 1'b1, 2'b10);
        sb_check();
        #2;
        rstn = 1'b0;
        #1;
        push_exp("async_rst", disp(0, 0, 1), disp(0, 0, 0), 1'b0, 2'b00);
        sb_check();
        chk("async_rst_colon", {b_colon, a_colon}, 2'b11);
        chk("async_rst_tick", {b_tick, a_tick}, 2'b00);
        cyc();
        rstn = 1'b1;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
